btn_debounce_unit: RTL and testbench

//  Push-button debouncer with an integrated sample-tick generator.
//  - A free-running divider produces a one-cycle sample strobe, clk_flag.
//  - The synchronised button is shifted into a history register on each strobe.
//  - o_btn changes only when the whole history agrees.
//  - Sits between a raw board pin and user control logic.

---
 rtl/btn_debounce_unit.sv | 83 ++++++++
 tb/tb_btn_debounce_unit.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/btn_debounce_unit.sv
// Push-button debouncer: 2-flop synchroniser, free-running sample strobe, shift-history filter.
// Optional registered press/release pulses when DEBOUNCE_EDGE_EN is defined.
module btn_debounce_unit #(
  parameter int CLK_DIV   = 4,
  parameter int SHIFT_LEN = 4
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic i_btn,
  output logic clk_flag,
  output logic o_btn
`ifdef DEBOUNCE_EDGE_EN
  ,
  output logic o_press,
  output logic o_release
`endif
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 clk_flag_q, clk_flag_d;
  logic                 sync1_q, sync1_d;
  logic                 btn_s_q, btn_s_d;
  logic [SHIFT_LEN-1:0] hist_q, hist_d;
  logic                 o_btn_q, o_btn_d;
`ifdef DEBOUNCE_EDGE_EN
  logic                 o_press_q, o_press_d;
  logic                 o_release_q, o_release_d;
`endif

  always_comb begin
    cnt_d      = (cnt_q == CW'(CLK_DIV - 1)) ? '0 : cnt_q + CW'(1);
    // Strobe is registered, so it appears the cycle after the terminal count.
    clk_flag_d = (cnt_q == CW'(CLK_DIV - 1));
    sync1_d    = i_btn;
    btn_s_d    = sync1_q;
    hist_d     = hist_q;
    if (clk_flag_q) hist_d = {hist_q[SHIFT_LEN-2:0], btn_s_q};
    o_btn_d    = o_btn_q;
    if (&hist_q)       o_btn_d = 1'b1;
    else if (~|hist_q) o_btn_d = 1'b0;
`ifdef DEBOUNCE_EDGE_EN
    // Pulses line up with the first cycle o_btn shows its new level.
    o_press_d   = o_btn_d & ~o_btn_q;
    o_release_d = ~o_btn_d & o_btn_q;
`endif
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_q       <= '0;
      clk_flag_q  <= 1'b0;
      sync1_q     <= 1'b0;
      btn_s_q     <= 1'b0;
      hist_q      <= '0;
      o_btn_q     <= 1'b0;
`ifdef DEBOUNCE_EDGE_EN
      o_press_q   <= 1'b0;
      o_release_q <= 1'b0;
`endif
    end else begin
      cnt_q       <= cnt_d;
      clk_flag_q  <= clk_flag_d;
      sync1_q     <= sync1_d;
      btn_s_q     <= btn_s_d;
      hist_q      <= hist_d;
      o_btn_q     <= o_btn_d;
`ifdef DEBOUNCE_EDGE_EN
      o_press_q   <= o_press_d;
      o_release_q <= o_release_d;
`endif
    end
  end

  assign clk_flag  = clk_flag_q;
  assign o_btn     = o_btn_q;
`ifdef DEBOUNCE_EDGE_EN
  assign o_press   = o_press_q;
  assign o_release = o_release_q;
`endif

endmodule

// File: tb/tb_btn_debounce_unit.sv
// Directed bench for btn_debounce_unit (CLK_DIV=4, SHIFT_LEN=4); edge pulses checked when DEBOUNCE_EDGE_EN is defined.
module tb_btn_debounce_unit;

  logic sys_clk = 1'b0;
  logic sys_rst_n;
  logic i_btn;
  logic clk_flag;
  logic o_btn;
`ifdef DEBOUNCE_EDGE_EN
  logic o_press, o_release;
`endif

  int checks = 0;
  int errors = 0;
  int edge_n = 0;  // rising edges since last reset release

  always #5 sys_clk = ~sys_clk;

  btn_debounce_unit #(.CLK_DIV(4), .SHIFT_LEN(4)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .i_btn     (i_btn),
    .clk_flag  (clk_flag),
    .o_btn     (o_btn)
`ifdef DEBOUNCE_EDGE_EN
    ,
    .o_press   (o_press),
    .o_release (o_release)
`endif
  );

  task automatic tick();
    @(posedge sys_clk);
    #1;
    edge_n++;
  endtask

  // Edge at which o_btn should first show a clean step applied just after edge e.
  function automatic int rise_edge(input int e);
    int m;
    m = e + 3;
    while (m % 4 != 1) m++;
    return m + 13;
  endfunction

  task automatic test_reset();
    sys_rst_n = 1'b0;
    i_btn     = 1'b0;
    #10;
    checks++;
    if (o_btn !== 1'b0 || clk_flag !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: o_btn=%b clk_flag=%b, expected 0 0", o_btn, clk_flag);
    end
`ifdef DEBOUNCE_EDGE_EN
    checks++;
    if (o_press !== 1'b0 || o_release !== 1'b0) begin
      errors++;
      $display("FAIL reset_edges: press=%b release=%b, expected 0 0", o_press, o_release);
    end
`endif
    #10;
    sys_rst_n = 1'b1;
    edge_n    = 0;
    for (int i = 0; i < 24; i++) begin
      tick();
      checks++;
      if (clk_flag !== (edge_n % 4 == 0) || o_btn !== 1'b0) begin
        errors++;
        $display("FAIL idle_strobe: edge %0d clk_flag=%b o_btn=%b, expected %b 0",
                 edge_n, clk_flag, o_btn, (edge_n % 4 == 0));
      end
    end
  endtask

  task automatic test_clean_press();
    int exp_e;
    exp_e = rise_edge(edge_n);
    i_btn = 1'b1;
    while (edge_n < exp_e + 8) begin
      tick();
      checks++;
      if (o_btn !== (edge_n >= exp_e) || clk_flag !== (edge_n % 4 == 0)) begin
        errors++;
        $display("FAIL clean_press: edge %0d o_btn=%b clk_flag=%b, expected %b %b (rise at %0d)",
                 edge_n, o_btn, clk_flag, (edge_n >= exp_e), (edge_n % 4 == 0), exp_e);
      end
    end
  endtask

  task automatic test_bounce();
    logic [9:0] pat;
    int start, rises;
    logic prev;
    i_btn = 1'b0;
    start = edge_n;
    while (o_btn !== 1'b0 && edge_n < start + 25) tick();
    checks++;
    if (o_btn !== 1'b0) begin
      errors++;
      $display("FAIL bounce_prep: o_btn=%b after %0d cycles, expected 0", o_btn, edge_n - start);
    end
    pat = 10'b1011011101;
    for (int i = 0; i < 10; i++) begin
      i_btn = pat[i];
      tick();
      checks++;
      if (o_btn !== 1'b0) begin
        errors++;
        $display("FAIL bounce_hold: bounce cycle %0d o_btn=%b, expected 0", i, o_btn);
      end
    end
    i_btn = 1'b1;
    start = edge_n;
    rises = 0;
    prev  = o_btn;
    for (int i = 0; i < 19; i++) begin
      tick();
      if (o_btn !== prev) rises++;
      prev = o_btn;
    end
    checks++;
    if (o_btn !== 1'b1 || rises != 1) begin
      errors++;
      $display("FAIL bounce_settle: o_btn=%b transitions=%0d, expected 1 and 1", o_btn, rises);
    end
  endtask

  task automatic test_release_glitch();
    i_btn = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    i_btn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (o_btn !== 1'b1) begin
        errors++;
        $display("FAIL release_glitch: cycle %0d o_btn=%b, expected 1", i, o_btn);
      end
    end
  endtask

  task automatic test_reset_mid();
    int exp_e;
    while (edge_n % 4 != 0) tick();  // land in a cycle where clk_flag is high
    checks++;
    if (clk_flag !== 1'b1 || o_btn !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: clk_flag=%b o_btn=%b, expected 1 1", clk_flag, o_btn);
    end
    #2;
    sys_rst_n = 1'b0;
    #1;
    checks++;
    if (o_btn !== 1'b0 || clk_flag !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: o_btn=%b clk_flag=%b, expected 0 0", o_btn, clk_flag);
    end
    tick();
    sys_rst_n = 1'b1;
    edge_n    = 0;
    // History must have been cleared: i_btn=1 needs four fresh strobes.
    exp_e = rise_edge(0);
    while (edge_n < exp_e + 2) begin
      tick();
      checks++;
      if (o_btn !== (edge_n >= exp_e) || clk_flag !== (edge_n % 4 == 0)) begin
        errors++;
        $display("FAIL post_reset: edge %0d o_btn=%b clk_flag=%b, expected %b %b",
                 edge_n, o_btn, clk_flag, (edge_n >= exp_e), (edge_n % 4 == 0));
      end
    end
  endtask

`ifdef DEBOUNCE_EDGE_EN
  task automatic test_edges();
    int n_press, n_rel, bad;
    logic prev;
    for (int ph = 0; ph < 2; ph++) begin
      i_btn   = (ph == 1);
      n_press = 0;
      n_rel   = 0;
      bad     = 0;
      prev    = o_btn;
      for (int i = 0; i < 30; i++) begin
        tick();
        if (o_press)   n_press++;
        if (o_release) n_rel++;
        if (o_press   !== (o_btn & ~prev)) bad++;
        if (o_release !== (~o_btn & prev)) bad++;
        prev = o_btn;
      end
      checks++;
      if (n_press != ph || n_rel != 1 - ph || bad != 0 || o_btn !== i_btn) begin
        errors++;
        $display("FAIL edge_pulse: phase %0d press=%0d release=%0d misaligned=%0d o_btn=%b, expected %0d %0d 0 %b",
                 ph, n_press, n_rel, bad, o_btn, ph, 1 - ph, i_btn);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_release_glitch();
    test_reset_mid();
`ifdef DEBOUNCE_EDGE_EN
    test_edges();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
